// File: rtl/buffer_codigo.sv
// Key-entry buffer behind the keypad scanner: debounces scanner activity into single key
// accepts, keeps a BCD digit buffer with backspace/clear, and releases the code on enter.
module buffer_codigo #(
  parameter int unsigned NDIG    = 4,
  parameter int unsigned DEB_CYC = 3,
  parameter int unsigned GAP_CYC = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 digito,
  input  logic                       cambio_digito,
  input  logic                       enter_sync,
  output logic [4*NDIG-1:0]          buffer,
  output logic [$clog2(NDIG+1)-1:0]  count,
  output logic                       key_pulse,
  output logic [3:0]                 key_code,
  output logic                       overflow,
  output logic [4*NDIG-1:0]          code_out,
  output logic [$clog2(NDIG+1)-1:0]  code_len,
  output logic                       code_valid
);

  localparam int unsigned CW = $clog2(NDIG + 1);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);
  localparam int unsigned DW = $clog2(DEB_CYC + 1);
  localparam int unsigned BW = 4 * NDIG;

  localparam logic [CW-1:0] NDIG_C   = CW'(NDIG);
  localparam logic [GW-1:0] GAP_C    = GW'(GAP_CYC);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB,
    S_HELD
  } state_t;

  state_t          state_q;
  logic [3:0]      key_q;
  logic [DW-1:0]   cnt_q;
  logic [GW-1:0]   gap_q, gap_d;
  logic            cd_prev_q;
  logic            en_prev_q;

  logic [BW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   count_q, count_d;
  logic            kp_q, kp_d;
  logic [3:0]      kc_q, kc_d;
  logic            ovf_q, ovf_d;
  logic [BW-1:0]   code_q, code_d;
  logic [CW-1:0]   len_q, len_d;
  logic            cv_q, cv_d;

  logic act_c, mismatch_c, gap_full_c, accept_c, enter_c;

  always_comb begin
    act_c      = cambio_digito ^ cd_prev_q;
    mismatch_c = act_c && (digito != {1'b0, key_q});
    gap_full_c = (gap_q == GAP_C);
    accept_c   = (state_q == S_DEB) && !mismatch_c && !gap_full_c && (cnt_q == DEB_LAST);
    enter_c    = enter_sync && !en_prev_q && (count_q != '0);
  end

  always_comb begin
    gap_d = gap_q;
    if (act_c) begin
      gap_d = '0;
    end else if (!gap_full_c) begin
      gap_d = gap_q + 1'b1;
    end
  end

  // Enter takes precedence: a key accepted on the enter edge still reports its
  // code, but its buffer effect (and any overflow) is dropped.
  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    kp_d    = accept_c;
    kc_d    = accept_c ? key_q : kc_q;
    ovf_d   = 1'b0;
    code_d  = code_q;
    len_d   = len_q;
    cv_d    = 1'b0;
    if (enter_c) begin
      code_d  = buf_q;
      len_d   = count_q;
      cv_d    = 1'b1;
      buf_d   = '0;
      count_d = '0;
    end else if (accept_c) begin
      if (key_q <= 4'd9) begin
        if (count_q < NDIG_C) begin
          buf_d   = {buf_q[BW-5:0], key_q};
          count_d = count_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (key_q == 4'hE) begin
        if (count_q != '0) begin
          buf_d   = {4'h0, buf_q[BW-1:4]};
          count_d = count_q - 1'b1;
        end
      end else if (key_q == 4'hF) begin
        buf_d   = '0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (act_c && !digito[4]) begin
            key_q   <= digito[3:0];
            cnt_q   <= '0;
            state_q <= S_DEB;
          end
        end
        S_DEB: begin
          if (mismatch_c || gap_full_c) begin
            state_q <= S_IDLE;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= S_HELD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HELD: begin
          if (gap_full_c) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q     <= GAP_C;
      cd_prev_q <= 1'b0;
      en_prev_q <= 1'b0;
      buf_q     <= '0;
      count_q   <= '0;
      kp_q      <= 1'b0;
      kc_q      <= '0;
      ovf_q     <= 1'b0;
      code_q    <= '0;
      len_q     <= '0;
      cv_q      <= 1'b0;
    end else begin
      gap_q     <= gap_d;
      cd_prev_q <= cambio_digito;
      en_prev_q <= enter_sync;
      buf_q     <= buf_d;
      count_q   <= count_d;
      kp_q      <= kp_d;
      kc_q      <= kc_d;
      ovf_q     <= ovf_d;
      code_q    <= code_d;
      len_q     <= len_d;
      cv_q      <= cv_d;
    end
  end

  assign buffer     = buf_q;
  assign count      = count_q;
  assign key_pulse  = kp_q;
  assign key_code   = kc_q;
  assign overflow   = ovf_q;
  assign code_out   = code_q;
  assign code_len   = len_q;
  assign code_valid = cv_q;

endmodule

// File: tb/tb_buffer_codigo.sv
// Directed scoreboard bench for buffer_codigo: expected key accepts and enter snapshots
// are queued as stimulus is driven and checked when the DUT pulses.
module tb_buffer_codigo;

  localparam int unsigned NDIG    = 4;
  localparam int unsigned DEB_CYC = 3;
  localparam int unsigned GAP_CYC = 8;

  logic        clk;
  logic        rst;
  logic [4:0]  digito;
  logic        cambio_digito;
  logic        enter_sync;
  logic [15:0] buffer;
  logic [2:0]  count;
  logic        key_pulse;
  logic [3:0]  key_code;
  logic        overflow;
  logic [15:0] code_out;
  logic [2:0]  code_len;
  logic        code_valid;

  buffer_codigo #(
    .NDIG    (NDIG),
    .DEB_CYC (DEB_CYC),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .digito        (digito),
    .cambio_digito (cambio_digito),
    .enter_sync    (enter_sync),
    .buffer        (buffer),
    .count         (count),
    .key_pulse     (key_pulse),
    .key_code      (key_code),
    .overflow      (overflow),
    .code_out      (code_out),
    .code_len      (code_len),
    .code_valid    (code_valid)
  );

  typedef struct {
    logic [3:0]  code;
    logic [15:0] bufv;
    logic [2:0]  cnt;
    logic        ovf;
    int unsigned at;
  } key_exp_t;

  typedef struct {
    logic [15:0] code;
    logic [2:0]  len;
    int unsigned at;
  } code_exp_t;

  key_exp_t    kq[$];
  code_exp_t   cq[$];
  int unsigned cyc;
  int unsigned n_tests;
  int unsigned n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One press: a cambio_digito toggle every 4 cycles, optional enter rise enter_off
  // cycles after the first toggle, then release and enough silence to return to IDLE.
  task automatic press(input logic [4:0] k, input int unsigned ntog, input int enter_off,
                       input bit acc, input logic [15:0] eb, input logic [2:0] ec,
                       input logic eo);
    key_exp_t e;
    digito = k;
    if (acc) begin
      e.code = k[3:0];
      e.bufv = eb;
      e.cnt  = ec;
      e.ovf  = eo;
      e.at   = cyc + 1 + DEB_CYC;
      kq.push_back(e);
    end
    for (int c = 0; c < int'(ntog * 4); c++) begin
      if (c % 4 == 0) cambio_digito = ~cambio_digito;
      if (c == enter_off) enter_sync = 1'b1;
      step();
    end
    digito = 5'd16;
    step(GAP_CYC + 2);
    enter_sync = 1'b0;
    step();
  endtask

  task automatic key(input logic [3:0] k, input logic [15:0] eb, input logic [2:0] ec,
                     input logic eo);
    press({1'b0, k}, 5, -1, 1'b1, eb, ec, eo);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " buffer"}, 32'(buffer), 32'd0);
    chk({tag, " count"}, 32'(count), 32'd0);
    chk({tag, " key_pulse"}, 32'(key_pulse), 32'd0);
    chk({tag, " key_code"}, 32'(key_code), 32'd0);
    chk({tag, " overflow"}, 32'(overflow), 32'd0);
    chk({tag, " code_out"}, 32'(code_out), 32'd0);
    chk({tag, " code_len"}, 32'(code_len), 32'd0);
    chk({tag, " code_valid"}, 32'(code_valid), 32'd0);
  endtask

  initial begin
    key_exp_t  ke;
    code_exp_t ce;
    code_exp_t ne;
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    digito        = 5'd16;
    cambio_digito = 1'b0;
    enter_sync    = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (key_pulse === 1'b1) begin
          if (kq.size() == 0) begin
            chk("key_pulse stray", 32'(key_pulse), 32'd0);
          end else begin
            ke = kq.pop_front();
            chk("key_code", 32'(key_code), 32'(ke.code));
            chk("key buffer", 32'(buffer), 32'(ke.bufv));
            chk("key count", 32'(count), 32'(ke.cnt));
            chk("key overflow", 32'(overflow), 32'(ke.ovf));
            chk("key latency cycle", cyc, ke.at);
          end
        end else if (overflow !== 1'b0) begin
          chk("overflow stray", 32'(overflow), 32'd0);
        end
        if (code_valid === 1'b1) begin
          if (cq.size() == 0) begin
            chk("code_valid stray", 32'(code_valid), 32'd0);
          end else begin
            ce = cq.pop_front();
            chk("code_out", 32'(code_out), 32'(ce.code));
            chk("code_len", 32'(code_len), 32'(ce.len));
            chk("enter latency cycle", cyc, ce.at);
          end
        end
      end
    join_none

    step(3);
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Single key
    key(4'd5, 16'h0005, 3'd1, 1'b0);
    chk("buffer after 5", 32'(buffer), 32'h0005);
    chk("count after 5", 32'(count), 32'd1);

    // Bounce: press then immediate release, then 3/6 alternation
    digito = 5'd3;  cambio_digito = ~cambio_digito; step();
    digito = 5'd16; cambio_digito = ~cambio_digito; step();
    step(GAP_CYC + 2);
    for (int i = 0; i < 6; i++) begin
      digito = (i % 2 == 0) ? 5'd3 : 5'd6;
      cambio_digito = ~cambio_digito;
      step();
    end
    digito = 5'd16; cambio_digito = ~cambio_digito; step();
    step(GAP_CYC + 4);
    chk("buffer after bounce", 32'(buffer), 32'h0005);
    chk("count after bounce", 32'(count), 32'd1);

    // Fill, overflow, backspace, clear, non-digit, backspace on empty
    key(4'hF, 16'h0000, 3'd0, 1'b0);
    key(4'd1, 16'h0001, 3'd1, 1'b0);
    key(4'd2, 16'h0012, 3'd2, 1'b0);
    key(4'd3, 16'h0123, 3'd3, 1'b0);
    key(4'd4, 16'h1234, 3'd4, 1'b0);
    key(4'd7, 16'h1234, 3'd4, 1'b1);
    key(4'hE, 16'h0123, 3'd3, 1'b0);
    key(4'hF, 16'h0000, 3'd0, 1'b0);
    key(4'hA, 16'h0000, 3'd0, 1'b0);
    key(4'hE, 16'h0000, 3'd0, 1'b0);

    // Enter with two digits, held high, then enter on empty buffer
    key(4'd9, 16'h0009, 3'd1, 1'b0);
    key(4'd8, 16'h0098, 3'd2, 1'b0);
    ne.code = 16'h0098; ne.len = 3'd2; ne.at = cyc + 1;
    cq.push_back(ne);
    enter_sync = 1'b1;
    step();
    chk("buffer after enter", 32'(buffer), 32'd0);
    chk("count after enter", 32'(count), 32'd0);
    step(10);
    enter_sync = 1'b0;
    step(2);
    enter_sync = 1'b1;
    step(3);
    enter_sync = 1'b0;
    step(2);
    chk("code_out held", 32'(code_out), 32'h0098);
    chk("code_len held", 32'(code_len), 32'd2);

    // Enter edge coincides with the accept of "6"
    key(4'd4, 16'h0004, 3'd1, 1'b0);
    key(4'd2, 16'h0042, 3'd2, 1'b0);
    ne.code = 16'h0042; ne.len = 3'd2; ne.at = cyc + 1 + DEB_CYC;
    cq.push_back(ne);
    press(5'd6, 5, int'(DEB_CYC), 1'b1, 16'h0000, 3'd0, 1'b0);
    chk("buffer after enter+6", 32'(buffer), 32'd0);
    chk("count after enter+6", 32'(count), 32'd0);
    chk("key_code after enter+6", 32'(key_code), 32'd6);
    chk("code_out after enter+6", 32'(code_out), 32'h0042);

    // Reset during DEB of "1", then a fresh press is accepted
    digito = 5'd1; cambio_digito = ~cambio_digito; step();
    rst = 1'b1; cambio_digito = 1'b0;
    step(2);
    chk_all_zero("mid-press reset");
    rst = 1'b0;
    step(4);
    key(4'd1, 16'h0001, 3'd1, 1'b0);

    step(5);
    chk("pending key events", 32'(kq.size()), 32'd0);
    chk("pending enter events", 32'(cq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
